// File: rtl/keys_wb_if.sv
// ============================================================================
// Module      : keys_wb_if
// Description : Wishbone slave bus bundle for the keypad event block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keys_wb_if;
    logic [25:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

`default_nettype wire

// File: rtl/keys_wb.sv
// ============================================================================
// Module      : keys_wb
// Description : Debounces four active-low keys and queues press/release
//               events in a FIFO readable over Wishbone.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keys_wb #(
    parameter int FIFO_DEPTH   = 8,
    parameter int DEBOUNCE_RST = 16000
) (
    input  wire logic       wb_clk_i,
    input  wire logic       wb_rstn_i,
    keys_wb_if.slave        wb,
    input  wire logic [3:0] keys_n,
    output logic            int_o,
    output logic            wake_o
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [3:0]      r_sync1, r_sync2, r_state, r_pend;
    logic [15:0]     r_cnt [4];
    logic [15:0]     r_deb;
    logic            r_ie, r_norel, r_ovf, r_ack, r_int;
    logic [31:0]     r_dat;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [1:0]      w_idx;
    logic [3:0]      w_grant;
    logic            w_any, w_press, w_push, w_push_ok, w_pop, w_full, w_nempty;
    logic            w_req, w_wr;
    logic [31:0]     w_event, w_status, w_rdata;
    logic            w_unused;

    assign w_unused = ^{wb.wb_sel_i, wb.wb_adr_i[25:2], wb.wb_dat_i[31:16]};

    // Works with the clock stopped so the power block can wake on a key.
    assign wake_o   = |(~keys_n);

    assign int_o       = r_int;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;

    // Lowest-index pending key wins the single push slot this cycle.
    always_comb begin
        w_idx = 2'd0;
        if (r_pend[0])      w_idx = 2'd0;
        else if (r_pend[1]) w_idx = 2'd1;
        else if (r_pend[2]) w_idx = 2'd2;
        else if (r_pend[3]) w_idx = 2'd3;
        w_any   = |r_pend;
        w_grant = w_any ? (4'b0001 << w_idx) : 4'b0000;
        w_press = r_state[w_idx];
        w_push  = w_any & (w_press | ~r_norel);
        w_event = {1'b1, 22'd0, w_press, 6'd0, w_idx};
    end

    assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr      = w_req & wb.wb_we_i;
    assign w_nempty  = (r_count != '0);
    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop     = w_req & ~wb.wb_we_i & (wb.wb_adr_i[1:0] == 2'd1) & w_nempty;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_status  = (32'(r_count) << 16) | {22'd0, r_ovf, w_nempty, 4'd0, r_state};

    always_comb begin
        w_rdata = 32'd0;
        case (wb.wb_adr_i[1:0])
            2'd0:    w_rdata = w_status;
            2'd1:    w_rdata = w_nempty ? r_mem[r_rd_ptr] : 32'd0;
            2'd2:    w_rdata = {30'd0, r_norel, r_ie};
            default: w_rdata = {16'd0, r_deb};
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_state <= '0;
            r_pend  <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= ~keys_n;
            r_sync2 <= r_sync1;
            r_pend  <= r_pend & ~w_grant;
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] != r_state[k]) begin
                    if (r_cnt[k] == r_deb - 16'd1) begin
                        r_cnt[k]   <= '0;
                        r_state[k] <= r_sync2[k];
                        r_pend[k]  <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 16'd1;
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_int    <= 1'b0;
            r_ie     <= 1'b0;
            r_norel  <= 1'b0;
            r_deb    <= 16'(DEBOUNCE_RST);
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_ack <= w_req;
            r_int <= r_ie & (w_nempty | r_ovf);
            if (w_req) r_dat <= w_rdata;
            if (w_wr) begin
                case (wb.wb_adr_i[1:0])
                    2'd0:    if (wb.wb_dat_i[9]) r_ovf <= 1'b0;
                    2'd2:    {r_norel, r_ie} <= wb.wb_dat_i[1:0];
                    2'd3:    r_deb <= (wb.wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb.wb_dat_i[15:0];
                    default: ;
                endcase
            end
            // A new overflow outranks a simultaneous clear.
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_event;
    end

endmodule

`default_nettype wire

// File: tb/tb_keys_wb.sv
// ============================================================================
// Module      : tb_keys_wb
// Description : Directed self-checking bench for keys_wb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keys_wb;
    logic       clk_raw = 1'b0;
    logic       clk_en  = 1'b1;
    logic       clk;
    logic       rst_n;
    logic [3:0] keys_n;
    logic       int_o, wake_o;
    int         checks   = 0;
    int         failures = 0;
    logic [31:0] rd;

    keys_wb_if bus ();

    keys_wb #(.FIFO_DEPTH(8), .DEBOUNCE_RST(16000)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rst_n),
        .wb        (bus),
        .keys_n    (keys_n),
        .int_o     (int_o),
        .wake_o    (wake_o)
    );

    always #5 clk_raw = ~clk_raw;
    assign clk = clk_raw & clk_en;

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d   = 32'd0;
        @(negedge clk);
        bus.wb_adr_i = {24'd0, a};
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) begin d = bus.wb_dat_o; got = 1'b1; break; end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL read_timeout adr=%0d ack never seen", a);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] v);
        logic got;
        got = 1'b0;
        @(negedge clk);
        bus.wb_adr_i = {24'd0, a};
        bus.wb_dat_i = v;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) begin got = 1'b1; break; end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL write_timeout adr=%0d ack never seen", a);
        end
    endtask

    task automatic set_keys(input logic [3:0] k, input int wait_cycles);
        @(negedge clk);
        keys_n = k;
        repeat (wait_cycles) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.wb_ack_o); end
        checks++; if (bus.wb_dat_o !== 32'd0) begin failures++; $display("FAIL rst_dat got=%h exp=0", bus.wb_dat_o); end
        checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rst_int got=%b exp=0", int_o); end
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_status got=%h exp=0", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_event got=%h exp=0", rd); end
        wb_read(2'd2, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
        wb_read(2'd3, rd);
        checks++; if (rd !== 32'h0000_3E80) begin failures++; $display("FAIL rst_debounce got=%h exp=3e80", rd); end
    endtask

    task automatic test_single_press;
        wb_write(2'd3, 32'd8);
        set_keys(4'b1101, 20);
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0001_0102) begin failures++; $display("FAIL k2_status got=%h exp=00010102", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'h8000_0101) begin failures++; $display("FAIL k2_event got=%h exp=80000101", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL k2_empty got=%h exp=0", rd); end
        set_keys(4'b1111, 20);
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'h8000_0001) begin failures++; $display("FAIL k2_release got=%h exp=80000001", rd); end
    endtask

    task automatic test_glitch_wake;
        set_keys(4'b1110, 6);
        set_keys(4'b1111, 20);
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL glitch_status got=%h exp=0", rd); end
        @(negedge clk);
        clk_en = 1'b0;
        keys_n = 4'b1110; #1;
        checks++; if (wake_o !== 1'b1) begin failures++; $display("FAIL wake_on got=%b exp=1", wake_o); end
        keys_n = 4'b1111; #1;
        checks++; if (wake_o !== 1'b0) begin failures++; $display("FAIL wake_off got=%b exp=0", wake_o); end
        @(negedge clk_raw);
        clk_en = 1'b1;
    endtask

    task automatic test_all_keys_irq;
        wb_write(2'd2, 32'd1);
        set_keys(4'b0000, 20);
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0004_010F) begin failures++; $display("FAIL all_status got=%h exp=0004010f", rd); end
        checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", int_o); end
        for (int i = 0; i < 4; i++) begin
            wb_read(2'd1, rd);
            checks++;
            if (rd !== (32'h8000_0100 | 32'(i))) begin
                failures++; $display("FAIL all_event%0d got=%h exp=%h", i, rd, 32'h8000_0100 | 32'(i));
            end
        end
        checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", int_o); end
        @(posedge clk); #1;
        checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", int_o); end
        set_keys(4'b1111, 20);
        for (int i = 0; i < 4; i++) begin
            wb_read(2'd1, rd);
            checks++;
            if (rd !== (32'h8000_0000 | 32'(i))) begin
                failures++; $display("FAIL rel_event%0d got=%h exp=%h", i, rd, 32'h8000_0000 | 32'(i));
            end
        end
        wb_write(2'd2, 32'd0);
    endtask

    task automatic test_overflow;
        wb_write(2'd2, 32'd2);
        for (int i = 0; i < 9; i++) begin
            set_keys(4'b1110, 14);
            set_keys(4'b1111, 14);
        end
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0008_0300) begin failures++; $display("FAIL ovf_status got=%h exp=00080300", rd); end
        checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL ovf_noirq got=%b exp=0", int_o); end
        wb_write(2'd0, 32'h0000_0200);
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0008_0100) begin failures++; $display("FAIL ovf_clear got=%h exp=00080100", rd); end
        // Pop request lands on the same edge as the pending push.
        set_keys(4'b1110, 9);
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'h8000_0100) begin failures++; $display("FAIL popush_data got=%h exp=80000100", rd); end
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0008_0101) begin failures++; $display("FAIL popush_status got=%h exp=00080101", rd); end
        set_keys(4'b1111, 14);
        for (int i = 0; i < 8; i++) begin
            wb_read(2'd1, rd);
            checks++; if (rd !== 32'h8000_0100) begin failures++; $display("FAIL drain%0d got=%h exp=80000100", i, rd); end
        end
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL drain_status got=%h exp=0", rd); end
    endtask

    task automatic test_norel_debounce;
        set_keys(4'b1011, 14);
        set_keys(4'b1111, 14);
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'h0001_0100) begin failures++; $display("FAIL norel_status got=%h exp=00010100", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'h8000_0102) begin failures++; $display("FAIL norel_event got=%h exp=80000102", rd); end
        wb_read(2'd1, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL norel_empty got=%h exp=0", rd); end
        wb_write(2'd3, 32'd1);
        wb_read(2'd3, rd);
        checks++; if (rd !== 32'd4) begin failures++; $display("FAIL deb_min got=%h exp=4", rd); end
        wb_write(2'd3, 32'h0001_2345);
        wb_read(2'd3, rd);
        checks++; if (rd !== 32'h0000_2345) begin failures++; $display("FAIL deb_upper got=%h exp=2345", rd); end
    endtask

    task automatic test_reset_abort;
        set_keys(4'b0111, 14);
        set_keys(4'b1111, 14);
        @(negedge clk);
        bus.wb_adr_i = 26'd1;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b exp=0", bus.wb_ack_o); end
        checks++; if (bus.wb_dat_o !== 32'd0) begin failures++; $display("FAIL abort_dat got=%h exp=0", bus.wb_dat_o); end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL abort_status got=%h exp=0", rd); end
        wb_read(2'd2, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL abort_ctrl got=%h exp=0", rd); end
        wb_read(2'd3, rd);
        checks++; if (rd !== 32'h0000_3E80) begin failures++; $display("FAIL abort_deb got=%h exp=3e80", rd); end
    endtask

    initial begin
        rst_n        = 1'b0;
        keys_n       = 4'b1111;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_press;
        test_glitch_wake;
        test_all_keys_irq;
        test_overflow;
        test_norel_debounce;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/keys_wb.md
# keys_wb

Wishbone slave that debounces the four active-low keypad inputs K1..K4 and queues press/release events in an 8-entry FIFO for the CPU. It is the upstream event source for the keypad: it feeds the interrupt vector as `cpu_irq[5]` and drives the power block's `wake` input. It decodes at `0xa000_0000` in the system controller address map and shares the common CPU Wishbone bus with the other slaves.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of two.
- `DEBOUNCE_RST`, default 16000: reset value of the DEBOUNCE register (1 ms at 16 MHz).

Ports:
- `wb_clk_i`  in  1: system clock; the only clock in the block.
- `wb_rstn_i`  in  1: reset, asynchronous, active-low.
- `wb_adr_i`  in  26: word address; only bits [1:0] are decoded.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data, registered.
- `wb_we_i`  in  1: write enable.
- `wb_sel_i`  in  4: byte selects; ignored, all accesses are treated as full-word.
- `wb_stb_i`  in  1: strobe.
- `wb_cyc_i`  in  1: cycle, already qualified with chip select.
- `wb_ack_o`  out  1: acknowledge, registered.
- `keys_n`  in  4: raw K4..K1, active-low, asynchronous.
- `int_o`  out  1: level interrupt.
- `wake_o`  out  1: combinational OR of the inverted raw `keys_n`. It does not depend on the clock, so it works while `wb_clk_i` is stopped.

## Operation

Input path:
- Each key passes through a 2-flop synchronizer, then a per-key 16-bit stability counter.
- While the synced value differs from the debounced state, the counter increments. Otherwise it clears to 0.
- When the counter reaches DEBOUNCE, the debounced state flips, the counter clears, and the key's pending flag sets.

Event queue:
- Each cycle, an arbiter pushes the lowest-index pending key into the FIFO and clears that key's pending flag.
- Event format: bit31 = 1 (valid), bit8 = 1 for press / 0 for release, bits[1:0] = key index (0 = K1).
- If CTRL.NOREL = 1, release events clear their pending flag without being pushed.

Registers (word offsets):
- 0 STATUS:
  - Read: [3:0] debounced state (1 = pressed), [8] FIFO not empty, [9] overflow (sticky), [19:16] FIFO count.
  - Write: writing 1 to bit 9 clears overflow; all other bits are ignored.
- 1 EVENT (RO):
  - A read returns the FIFO head and pops it.
  - If the FIFO is empty, the read returns 0 and does not pop.
  - Writes are acknowledged and ignored.
- 2 CTRL (RW): [0] IE, [1] NOREL. Reset value 0.
- 3 DEBOUNCE (RW): [15:0] stability count.
  - Written values below 4 are stored as 4.
  - Upper bits read as 0.

FIFO boundary rules:
- Push while full with no pop in the same cycle: the new event is dropped and overflow is set.
- Pop and push in the same cycle: both take effect; the count is unchanged and no overflow occurs.
- Read and write pointers are `log2(FIFO_DEPTH)` bits wide and wrap naturally.
- Count is held in a separate `log2(FIFO_DEPTH)+1`-bit register.

Interrupt:
- `int_o` = IE & (not empty | overflow), registered.

## Timing

Reset values:
- `wb_ack_o` = 0, `wb_dat_o` = 0, `int_o` = 0.
- FIFO empty, overflow = 0, debounced state = 0000, pending flags = 0, counters = 0, CTRL = 0, DEBOUNCE = DEBOUNCE_RST.
- Reset asserted mid-transfer or mid-debounce returns everything to these values immediately. No ack is issued for an aborted access.

Wishbone handshake:
- `wb_ack_o` asserts in the cycle after `wb_cyc_i & wb_stb_i & !wb_ack_o`, for exactly one cycle.
- Consecutive accesses therefore complete at most every 2 cycles.
- Read data is valid while `wb_ack_o` is high.
- Register writes and the EVENT pop take effect on the ack cycle. A request held across the ack pops exactly once.

Key-to-event latency:
- Stable input change to debounced flip: 2 cycles (synchronizer) + DEBOUNCE cycles.
- Flip to FIFO entry: 1 cycle plus arbitration.
- Arbitration delay: at most 3 extra cycles when all four keys flip together.
- A glitch shorter than DEBOUNCE cycles produces no event.

Interrupt latency: `int_o` follows the FIFO/overflow state with a 1-cycle lag. After the pop that empties the FIFO, `int_o` drops on the next cycle.

## Test plan

- Reset, then read all four registers: STATUS = 0, EVENT = 0, CTRL = 0, DEBOUNCE = 16000 (0x3E80).
- Write DEBOUNCE = 8. Hold K2 low for 20 cycles -> STATUS[3:0] = 0010 and count = 1. EVENT read = 0x8000_0101. The following EVENT read returns 0.
- Pulse K1 low for 6 cycles with DEBOUNCE = 8 -> no event and STATUS unchanged. Assert K1 low again -> `wake_o` follows within 0 cycles, with the clock gated.
- Press all four keys in the same cycle -> FIFO holds events for key indices 0, 1, 2, 3 in order, count = 4. With CTRL = 1 (IE), `int_o` rises; it falls 1 cycle after the fourth EVENT pop.
- Generate 9 presses without reading -> count = 8, overflow = 1. Write STATUS bit 9 -> overflow = 0. Pop while pushing on a full FIFO -> count stays 8, overflow stays 0.
- Set NOREL = 1, press and release K3 -> exactly one event (0x8000_0102). Write DEBOUNCE = 1 -> it reads back 4. Assert `wb_rstn_i` during a pending ack -> `wb_ack_o` is 0 and the FIFO is empty.
